// File: rtl/sequence_generator_if.sv
// Command/status bundle for sequence_generator: transfer request fields in,
// serial bit stream and status flags out.
interface sequence_generator_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RW    = 4
);
  localparam int unsigned LW = $clog2(WIDTH + 1);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [LW-1:0]    len;
  logic [RW-1:0]    reps;
  logic             out;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, len, reps,
    input  out, valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, len, reps,
    output out, valid, busy, done
  );
endinterface

// File: rtl/sequence_generator.sv
// Serialises the low len bits of a latched pattern MSB-first, reps times back to back,
// then pulses done for one cycle. All outputs are registered.
module sequence_generator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RW    = 4
) (
  input logic                clock,
  input logic                reset,
  sequence_generator_if.slave bus
);
  localparam int unsigned LW = $clog2(WIDTH + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    bitcnt_q, bitcnt_d;
  logic [RW-1:0]    repcnt_q, repcnt_d;
  logic [LW-1:0]    len_eff;
  logic [WIDTH-1:0] pat_shifted;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Out-of-range lengths saturate so the bit index can never leave the pattern.
  assign len_eff = (bus.len > LW'(WIDTH)) ? LW'(WIDTH) : bus.len;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    bitcnt_d = bitcnt_q;
    repcnt_d = repcnt_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          pat_d = bus.pattern;
          len_d = len_eff;
          if ((len_eff == '0) || (bus.reps == '0)) begin
            state_d  = StDone;
            bitcnt_d = '0;
            repcnt_d = '0;
          end else begin
            state_d  = StShift;
            bitcnt_d = len_eff - LW'(1);
            repcnt_d = bus.reps - RW'(1);
          end
        end
      end
      StShift: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bitcnt_q != '0) begin
          bitcnt_d = bitcnt_q - LW'(1);
        end else if (repcnt_q != '0) begin
          // Reload straight into the next repetition: no gap cycle.
          bitcnt_d = len_q - LW'(1);
          repcnt_d = repcnt_q - RW'(1);
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are computed from next state so they land in the register alongside it.
    pat_shifted = pat_d >> bitcnt_d;
    valid_d     = (state_d == StShift);
    busy_d      = (state_d == StShift);
    done_d      = (state_d == StDone);
    out_d       = valid_d & pat_shifted[0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      pat_q    <= '0;
      len_q    <= '0;
      bitcnt_q <= '0;
      repcnt_q <= '0;
      out_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      bitcnt_q <= bitcnt_d;
      repcnt_q <= repcnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the maximum pattern length in bits.
REQ-002 SHALL have parameter RW, default 4, giving the width of the repeat-count input.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port start  input  1  request to begin transmission; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of an in-progress transmission.
REQ-007 SHALL have port pattern  input  WIDTH  bit pattern to serialize; latched on accepted start.
REQ-008 SHALL have port len  input  $clog2(WIDTH+1)  number of pattern bits to send, 0..WIDTH; latched on accepted start.
REQ-009 SHALL have port reps  input  RW  number of back-to-back pattern transmissions; latched on accepted start.
REQ-010 SHALL have port out  output  1  registered serial bit stream, one bit per clock.
REQ-011 SHALL have port valid  output  1  high in each cycle that out carries a pattern bit.
REQ-012 SHALL have port busy  output  1  high from the cycle after an accepted start through the last bit.
REQ-013 SHALL have port done  output  1  single-cycle pulse after normal completion.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; the reset state is IDLE.
REQ-015 SHALL accept start only in IDLE; start in SHIFT or DONE is ignored, with no queuing.
REQ-016 On an accepted start with len>0 and reps>0, SHALL latch pattern/len/reps and enter SHIFT.
- Bit counter loads len-1; repetition counter loads reps-1.
REQ-017 In SHIFT, out SHALL present pattern[bitcnt], MSB-first within the len-bit field (index len-1 down to 0), with valid=1 and busy=1.
- Latency: first bit appears in the cycle after the start edge.
REQ-018 When bitcnt reaches 0 and repcnt>0, SHALL reload bitcnt with len-1 and decrement repcnt.
- No idle gap between repetitions.
REQ-019 When bitcnt=0 and repcnt=0, SHALL enter DONE on the next edge.
REQ-020 In DONE, done SHALL be 1, with out=0, valid=0, busy=0, for exactly one cycle; then IDLE.
REQ-021 An accepted start with len=0 or reps=0 SHALL go directly to DONE.
- No valid bits are sent; done pulses one cycle after the start edge.
REQ-022 abort=1 in SHIFT SHALL force IDLE on the next edge.
- out=0, valid=0, busy=0; no done pulse.
- abort in IDLE or DONE has no effect.
REQ-023 If abort and start are both high in IDLE, start SHALL take effect; abort is ignored.
REQ-024 Total valid cycles for a transmission SHALL be exactly len*reps; the counters SHALL never wrap or underflow.
REQ-025 Pattern bits above index len-1 SHALL never appear on out.
REQ-026 In IDLE, out=0, valid=0, busy=0, done=0.
REQ-027 Changes to pattern/len/reps while busy SHALL NOT affect the transmission in progress.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for a clock edge, force IDLE, clear all counters and latched fields, and drive out=0, valid=0, busy=0, done=0.
REQ-029 Reset asserted mid-SHIFT SHALL abandon the transmission with no done pulse.
REQ-030 After reset deasserts, the first start SHALL be accepted on the first rising edge on which it is high.

Verification
REQ-031 SHALL cover: pattern=8'b11000100, len=8, reps=1, start one cycle -> out=1,1,0,0,0,1,0,0 on 8 consecutive valid cycles, then done for 1 cycle.
REQ-032 SHALL cover: pattern=8'bxxxx1001, len=4, reps=3 -> 12 valid cycles, out=1001 1001 1001 with no gap, busy high 12 cycles, one done pulse.
REQ-033 SHALL cover: len=0 (and separately reps=0) with start -> no valid cycles, done high in the cycle after start.
REQ-034 SHALL cover: abort asserted on the 3rd bit of an 8-bit send -> valid low from the next cycle, no done, a new start accepted in IDLE.
REQ-035 SHALL cover: reset driven low mid-SHIFT, between clock edges -> all outputs 0 immediately; after release, an 8-bit send runs from its MSB.
REQ-036 SHALL cover: start held high continuously with len=2, reps=1 -> the transfers are separated by one DONE cycle and one IDLE cycle, and start is ignored while busy.
